// File: rtl/jtcps2_keyload.sv
// CPS2 key loader: assembles the FN1 master key and the decrypt address limit
// from the download stream, XOR-checks the sequence and drives dec_en per access.
// Optional JTCPS2_KEYLOAD_LOCK_EN: once a good key is loaded, further downloads are ignored until reset.
module jtcps2_keyload #(
    parameter int KEY_BYTES = 8,
    parameter int LIM_BYTES = 2,
    parameter int AW        = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic                   prog_start,
    input  logic [7:0]             prog_data,
    input  logic [AW-1:0]          cpu_addr,
    input  logic                   cpu_asn,
    output logic [8*KEY_BYTES-1:0] key,
    output logic                   key_ok,
    output logic                   key_err,
    output logic                   dec_en,
    output logic                   busy,
    output logic [2:0]             dbg_state
);

    localparam int KW    = 8*KEY_BYTES;
    localparam int LW    = 8*LIM_BYTES;
    localparam int CW    = AW-8;
    localparam int MAXB  = (KEY_BYTES > LIM_BYTES) ? KEY_BYTES : LIM_BYTES;
    localparam int CNT_W = $clog2(MAXB+1);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES-1);
    localparam logic [CNT_W-1:0] LIM_LAST = CNT_W'(LIM_BYTES-1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY  = 3'd1,
        LIM  = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       acc, acc_nxt;
    logic [KW-1:0]    key_nxt;
    logic [LW-1:0]    limit, lim_nxt;
    logic             ok_nxt, err_nxt;
    logic             locked;
    logic             asn_q;

    logic [CW+LW-1:0] lim_wide;
    logic [CW-1:0]    lim_cmp;
    logic             addr_below;
    logic             unused_lim;

`ifdef JTCPS2_KEYLOAD_LOCK_EN
    assign locked = (state == DONE);
`else
    assign locked = 1'b0;
`endif

    assign busy      = (state == KEY) || (state == LIM) || (state == CHK);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            key     <= '0;
            limit   <= '0;
            key_ok  <= 1'b0;
            key_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            key     <= key_nxt;
            limit   <= lim_nxt;
            key_ok  <= ok_nxt;
            key_err <= err_nxt;
        end
    end

    // prog_start wins over a coincident prog_we; that byte is dropped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        key_nxt   = key;
        lim_nxt   = limit;
        ok_nxt    = key_ok;
        err_nxt   = key_err;
        if (prog_start && !locked) begin
            state_nxt = KEY;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            ok_nxt    = 1'b0;
            err_nxt   = 1'b0;
        end else if (prog_we) begin
            case (state)
                KEY: begin
                    key_nxt[8*cnt +: 8] = prog_data;
                    acc_nxt             = acc ^ prog_data;
                    if (cnt == KEY_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = LIM;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                LIM: begin
                    lim_nxt[8*cnt +: 8] = prog_data;
                    acc_nxt             = acc ^ prog_data;
                    if (cnt == LIM_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = CHK;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                CHK: begin
                    if (prog_data == acc) begin
                        state_nxt = DONE;
                        ok_nxt    = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        ok_nxt    = 1'b0;
                        err_nxt   = 1'b1;
                    end
                end
                DONE, ERR: begin
                    if (!locked) err_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Limit is in 256-word units: only its low AW-8 bits take part, zero-extended if narrower.
    assign lim_wide   = {{CW{1'b0}}, limit};
    assign lim_cmp    = lim_wide[CW-1:0];
    assign unused_lim = ^lim_wide;
    assign addr_below = (cpu_addr < {lim_cmp, 8'h00});

    // Captured once on the falling strobe, held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asn_q  <= 1'b1;
            dec_en <= 1'b0;
        end else begin
            asn_q <= cpu_asn;
            if (cpu_asn) begin
                dec_en <= 1'b0;
            end else if (asn_q) begin
                dec_en <= key_ok & addr_below;
            end
        end
    end

endmodule

// File: tb/tb_jtcps2_keyload.sv
// Randomised bench for jtcps2_keyload: a byte-level reference model predicts key,
// status and dec_en; a negedge monitor pops the expected queue and compares.
module tb_jtcps2_keyload;

    localparam int KB = 8;
    localparam int LB = 2;
    localparam int AW = 23;
    localparam int EW = 8*KB + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we, prog_start;
    logic [7:0]        prog_data;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_asn;
    logic [8*KB-1:0]   key;
    logic              key_ok, key_err, dec_en, busy;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    jtcps2_keyload #(.KEY_BYTES(KB), .LIM_BYTES(LB), .AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_start(prog_start),
        .prog_data(prog_data), .cpu_addr(cpu_addr), .cpu_asn(cpu_asn),
        .key(key), .key_ok(key_ok), .key_err(key_err), .dec_en(dec_en),
        .busy(busy), .dbg_state(dbg_state)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    logic          chk_req = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    // reference model
    logic [63:0] m_key;
    logic [15:0] m_limit;
    bit          m_ok, m_err, m_locked;
    int          m_phase;  // 0 idle, 1 loading, 2 finished

    function automatic bit m_dec(input logic [AW-1:0] a);
        longint lim_words;
        lim_words = longint'(m_limit % 17'd32768) * 256;
        return m_ok && (longint'(a) < lim_words);
    endfunction

    task automatic model_reset();
        m_key = '0; m_limit = '0; m_ok = 0; m_err = 0; m_locked = 0; m_phase = 0;
    endtask

    task automatic snap(input string nm, input logic exp_busy, input logic exp_dec);
        exp_q.push_back({m_key, m_ok, m_err, exp_busy, exp_dec});
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e, a;
        string nm;
        if (chk_req) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL queue_underflow: monitor saw a request with no expectation");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {key, key_ok, key_err, busy, dec_en};
                if (a === e) n_pass++;
                else $display("FAIL %s: got key=%h ok=%b err=%b busy=%b dec=%b, expected key=%h ok=%b err=%b busy=%b dec=%b",
                              nm, a[EW-1:4], a[3], a[2], a[1], a[0], e[EW-1:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b);
        prog_we = 1'b1; prog_data = b;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic start_seq(input bit coinc);
        prog_start = 1'b1;
        if (coinc) begin prog_we = 1'b1; prog_data = 8'hAA; end
        @(posedge clk); #1;
        prog_start = 1'b0; prog_we = 1'b0;
        if (!m_locked) begin m_ok = 0; m_err = 0; m_phase = 1; end
    endtask

    task automatic partial(input int n);
        logic [7:0] b;
        start_seq(0);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            send_byte(b);
            if (!m_locked) m_key[8*i +: 8] = b;
        end
    endtask

    task automatic download(input logic [63:0] k, input logic [15:0] l, input bit good, input bit coinc);
        logic [7:0] bytes[$];
        logic [7:0] x, chk;
        x = 8'h00;
        for (int i = 0; i < KB; i++) bytes.push_back(k[8*i +: 8]);
        for (int i = 0; i < LB; i++) bytes.push_back(l[8*i +: 8]);
        foreach (bytes[i]) x = x ^ bytes[i];
        chk = good ? x : (x ^ 8'($urandom_range(1, 255)));
        start_seq(coinc);
        for (int i = 0; i < KB + LB; i++) begin
            send_byte(bytes[i]);
            if (!m_locked && i < KB) m_key[8*i +: 8] = bytes[i];
            if (i == 2) snap("mid_key", !m_locked, 1'b0);
        end
        snap("pre_chk", !m_locked, 1'b0);
        send_byte(chk);
        if (!m_locked) begin
            m_limit = l; m_ok = good; m_err = !good; m_phase = 2;
`ifdef JTCPS2_KEYLOAD_LOCK_EN
            m_locked = good;
`endif
        end
        snap(good ? "chk_good" : "chk_bad", 1'b0, 1'b0);
    endtask

    task automatic overrun();
        send_byte(8'($urandom));
        if (m_phase == 2 && !m_locked) m_err = 1;
        snap("overrun", 1'b0, 1'b0);
    endtask

    task automatic access(input logic [AW-1:0] a);
        bit d;
        d = m_dec(a);
        cpu_addr = a; cpu_asn = 1'b0;
        @(posedge clk); #1;
        snap("dec_fall", 1'b0, d);
        cpu_addr = AW'($urandom);
        snap("dec_hold", 1'b0, d);
        cpu_asn = 1'b1;
        @(posedge clk); #1;
        snap("dec_rise", 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l, l15;
        rst = 1'b1; prog_we = 1'b0; prog_start = 1'b0; prog_data = '0;
        cpu_addr = '0; cpu_asn = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        snap("reset", 1'b0, 1'b0);
        access(23'h03FF00);
        access(23'h000000);

        download(64'h0807060504030201, 16'h0400, 1, 0);
        access(23'h03FF00);
        access(23'h040000);
        access(23'h03FFFF);
        overrun();
        access(23'h000100);

        download(64'h0807060504030201, 16'h0400, 0, 0);
        access(23'h000100);

        do_reset();
        start_seq(0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        do_reset();
        snap("after_rst", 1'b0, 1'b0);
        download({$urandom, $urandom}, 16'h0123, 1, 1);
        access(23'h012200);
        access(23'h012300);

        download({$urandom, $urandom}, 16'h0000, 1, 0);
        access(23'h000000);

        for (int it = 0; it < 8; it++) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) partial($urandom_range(1, 9));
            l   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            l15 = l % 16'h8000;
            download({$urandom, $urandom}, l, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            if (l15 != 0) access(AW'({l15, 8'h00} - 24'd1));
            access(AW'({l15, 8'h00}));
            access(AW'($urandom));
            if ($urandom_range(0, 1) == 1) overrun();
            if ($urandom_range(0, 1) == 1)
                download({$urandom, $urandom}, 16'($urandom), $urandom_range(0, 1) == 1, 0);
            access(AW'($urandom_range(0, 8388607)));
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
